mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Multi-cycle RV32I control FSM; successor to the current 6-state CU.
- Adds loads, stores, branches and JAL, a ready/wait memory handshake with timeout, and a sticky illegal-instruction halt.
- Parametrised ALU-op width.
- Sits between IR decode fields and the multi-cycle datapath (PC, IR, regfile, ALU, data memory).

Parameters:
- ALUOP_W, 4, width of alu_op; must be >=4; bits above [3] are driven 0.
- USE_MEM_READY, 1, 1: memory states wait for mem_ready; 0: mem_ready ignored, every memory state lasts exactly 1 cycle.
- WAIT_LIMIT, 15, maximum consecutive wait cycles in a memory state before a timeout; range 1..255.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- opcode, input, 7, IR[6:0]; stable from DECODE until the next FETCH.
- funct3, input, 3, IR[14:12].
- funct7, input, 7, IR[31:25].
- branch_taken, input, 1, datapath comparator result for the current branch.
- mem_ready, input, 1, data memory completes the access this cycle.
- alu_op, output, ALUOP_W, ALU operation select.
- rs2_imm_s, output, 1, ALU B source: 0 = rs2, 1 = immediate.
- w_data_s, output, 2, writeback source: 00 = ALU, 01 = imm (LUI), 10 = mem, 11 = PC+4.
- reg_write, output, 1, register file write enable.
- ir_write, output, 1, IR load enable.
- pc_write, output, 1, PC load enable.
- pc_src, output, 2, next PC: 00 = PC+4, 01 = branch target, 10 = jump target.
- mem_read, output, 1, data memory read request.
- mem_write, output, 1, data memory write request.
- illegal, output, 1, sticky: unknown opcode.
- timeout, output, 1, sticky: memory wait limit reached.
- state_o, output, 4, current state encoding (debug).

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0, including alu_op, illegal and timeout. Reset during a memory state drops mem_read/mem_write immediately.
- Output timing: outputs are registered, computed from next state, so each is valid during the whole cycle the FSM occupies its state. Any control not listed for a state is 0; w_data_s = 00 and pc_src = 00 unless stated.
- IDLE -> FETCH unconditionally.
- FETCH: ir_write=1, pc_write=1, pc_src=00. -> DECODE.
- DECODE: all enables 0. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0110111 -> WB_LUI
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode -> HALT with illegal=1.
- EXEC_R: rs2_imm_s=0, alu_op={funct7[5],funct3}. -> WB_ALU.
- EXEC_I: rs2_imm_s=1; alu_op={funct7[5],funct3} if funct3==101, else {0,funct3}. -> WB_ALU.
- WB_ALU: reg_write=1, w_data_s=00. -> FETCH.
- WB_LUI: reg_write=1, w_data_s=01. -> FETCH.
- MEM_ADDR: rs2_imm_s=1, alu_op=0000 (add). -> MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_read=1, held while waiting. On mem_ready -> WB_MEM.
- MEM_WR: mem_write=1, held while waiting. On mem_ready -> FETCH.
- WB_MEM: reg_write=1, w_data_s=10. -> FETCH.
- BRANCH: alu_op={1,000} (sub); pc_write=branch_taken, pc_src=01; branch_taken is sampled combinationally in this cycle. -> FETCH.
- JAL: reg_write=1, w_data_s=11, pc_write=1, pc_src=10. -> FETCH.
- Wait counter (8-bit):
  - Clears on entry to MEM_RD or MEM_WR.
  - Increments each cycle in those states with mem_ready=0.
  - When count == WAIT_LIMIT and mem_ready=0: -> HALT with timeout=1, mem_read/mem_write deasserted.
  - mem_ready=1 on the limit cycle completes normally; the handshake wins.
  - USE_MEM_READY=0: counter unused; MEM_RD/MEM_WR always advance after 1 cycle.
- HALT: all enables 0; illegal/timeout held. Exit only via rst_n.
- Cycle counts per instruction (no memory waits): R/I = 4, LUI = 3, load = 5, store = 4, branch = 3, JAL = 3.

Decomposition:
- Package riscv_cu_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL)
  - state encodings (4-bit)
  - W_ALU/W_IMM/W_MEM/W_PC4 and PC_SEQ/PC_BR/PC_JMP encodings
  - ALU_ADD and ALU_SUB codes.
- Sub-module cu_alu_decode: combinational funct3/funct7/instruction class -> alu_op, zero-extended to ALUOP_W.

Test Plan:
- ADD (opcode 0110011, funct7=0000000, funct3=000) -> states FETCH, DECODE, EXEC_R, WB_ALU; alu_op=0000; reg_write=1 for exactly 1 cycle; 4 cycles total.
- SRAI (0010011, funct3=101, funct7=0100000) -> alu_op=1101, rs2_imm_s=1. ADDI with funct7 bits set -> alu_op=0000.
- LW with mem_ready low for 3 cycles -> mem_read high for 4 cycles, then WB_MEM with w_data_s=10, reg_write=1.
- SW with mem_ready stuck low, WAIT_LIMIT=15 -> HALT after 15 wait cycles, timeout=1, mem_write=0; state holds until rst_n pulse.
- BEQ with branch_taken=1 -> pc_write=1, pc_src=01. With branch_taken=0 -> pc_write=0. Then JAL -> reg_write=1, w_data_s=11, pc_src=10.
- Opcode 1111111 -> illegal=1, HALT. Assert rst_n=0 mid-MEM_RD -> mem_read=0 asynchronously, state_o=IDLE.

Source files
------------

// File: rtl/riscv_cu_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit.
// Holds the opcode constants, the 4-bit state encoding, writeback/PC mux
// select encodings, ALU operation codes, the ALU decode class used by
// cu_alu_decode, and the bundle of registered datapath controls.
package riscv_cu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_ALU   = 4'd5,
        S_WB_LUI   = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_WB_MEM   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JAL      = 4'd12,
        S_HALT     = 4'd13
    } state_e;

    localparam logic [1:0] W_ALU = 2'b00;
    localparam logic [1:0] W_IMM = 2'b01;
    localparam logic [1:0] W_MEM = 2'b10;
    localparam logic [1:0] W_PC4 = 2'b11;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    // Which rule the ALU decoder applies for the state being entered.
    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_I    = 3'd2,
        CLS_ADD  = 3'd3,
        CLS_SUB  = 3'd4
    } alu_cls_e;

    // Single-bit and mux controls that are registered together.
    typedef struct packed {
        logic       rs2_imm_s;
        logic [1:0] w_data_s;
        logic       reg_write;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;

endpackage

// File: rtl/cu_alu_decode.sv
// Combinational ALU operation decoder.
// Ports:
//   cls_i        - decode rule for the state being entered
//   funct3_i     - IR[14:12]
//   funct7_b5_i  - IR[30], selects SUB/SRA variants
//   alu_op_o     - ALU operation, zero-extended to ALUOP_W
module cu_alu_decode
    import riscv_cu_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  alu_cls_e           cls_i,
    input  logic [2:0]         funct3_i,
    input  logic               funct7_b5_i,
    output logic [ALUOP_W-1:0] alu_op_o
);

    logic [3:0] op4;

    // Immediate ops only honour funct7[5] for the shift-right encoding,
    // because for every other I-type funct3 those bits are immediate data.
    always_comb begin
        op4 = ALU_ADD;
        case (cls_i)
            CLS_R:   op4 = {funct7_b5_i, funct3_i};
            CLS_I:   op4 = (funct3_i == 3'b101) ? {funct7_b5_i, funct3_i}
                                                 : {1'b0, funct3_i};
            CLS_SUB: op4 = ALU_SUB;
            default: op4 = ALU_ADD;
        endcase
        alu_op_o = ALUOP_W'(op4);
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM.
// Drives the PC/IR/regfile/ALU/data-memory datapath from IR decode fields.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   opcode/funct3/funct7  - IR decode fields (stable DECODE..next FETCH)
//   branch_taken          - comparator result, used combinationally in BRANCH
//   mem_ready             - data memory access completes this cycle
//   alu_op, rs2_imm_s     - ALU operation and B-operand source
//   w_data_s, reg_write   - writeback source and enable
//   ir_write, pc_write, pc_src - fetch / PC update controls
//   mem_read, mem_write   - data memory requests
//   illegal, timeout      - sticky halt causes
//   state_o               - current state (debug)
module mc_control_unit
    import riscv_cu_pkg::*;
#(
    parameter int ALUOP_W       = 4,
    parameter bit USE_MEM_READY = 1'b1,
    parameter int WAIT_LIMIT    = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               branch_taken,
    input  logic               mem_ready,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               rs2_imm_s,
    output logic [1:0]         w_data_s,
    output logic               reg_write,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               mem_read,
    output logic               mem_write,
    output logic               illegal,
    output logic               timeout,
    output logic [3:0]         state_o
);

    state_e             state_q, state_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;
    logic [7:0]         wait_q, wait_d;
    alu_cls_e           alu_cls;
    logic               mem_done;
    logic               wait_hit;
    logic               funct7_unused;

    assign funct7_unused = ^{funct7[6], funct7[4:0]};

    // Without a handshake every memory state is a single cycle.
    assign mem_done = !USE_MEM_READY || mem_ready;
    assign wait_hit = (wait_q == 8'(WAIT_LIMIT));

    cu_alu_decode #(.ALUOP_W(ALUOP_W)) u_alu_decode (
        .cls_i       (alu_cls),
        .funct3_i    (funct3),
        .funct7_b5_i (funct7[5]),
        .alu_op_o    (alu_op_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            alu_op_q  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            alu_op_q  <= alu_op_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            wait_q    <= wait_d;
        end
    end

    // Next state first, then controls decoded from that next state so the
    // registered outputs line up with the cycle the state is occupied.
    // The wait counter defaults to zero, which clears it on every entry to
    // a memory state; a ready on the limit cycle still completes normally.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        wait_d    = '0;
        ctrl_d    = '0;
        alu_cls   = CLS_NONE;

        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LUI:             state_d = S_WB_LUI;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_JAL:             state_d = S_JAL;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD, S_MEM_WR: begin
                if (mem_done) begin
                    state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                end else if (wait_hit) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB_ALU, S_WB_LUI, S_WB_MEM, S_BRANCH, S_JAL: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        case (state_d)
            S_FETCH: begin
                ctrl_d.ir_write = 1'b1;
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_src   = PC_SEQ;
            end
            S_EXEC_R: alu_cls = CLS_R;
            S_EXEC_I: begin
                ctrl_d.rs2_imm_s = 1'b1;
                alu_cls          = CLS_I;
            end
            S_WB_ALU: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.w_data_s  = W_ALU;
            end
            S_WB_LUI: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.w_data_s  = W_IMM;
            end
            S_MEM_ADDR: begin
                ctrl_d.rs2_imm_s = 1'b1;
                alu_cls          = CLS_ADD;
            end
            S_MEM_RD: ctrl_d.mem_read  = 1'b1;
            S_MEM_WR: ctrl_d.mem_write = 1'b1;
            S_WB_MEM: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.w_data_s  = W_MEM;
            end
            S_BRANCH: begin
                alu_cls       = CLS_SUB;
                ctrl_d.pc_src = PC_BR;
            end
            S_JAL: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.w_data_s  = W_PC4;
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_src    = PC_JMP;
            end
            default: ;
        endcase
    end

    assign alu_op    = alu_op_q;
    assign rs2_imm_s = ctrl_q.rs2_imm_s;
    assign w_data_s  = ctrl_q.w_data_s;
    assign reg_write = ctrl_q.reg_write;
    assign ir_write  = ctrl_q.ir_write;
    // The branch decision arrives during BRANCH itself, so it bypasses the register.
    assign pc_write  = ctrl_q.pc_write | ((state_q == S_BRANCH) & branch_taken);
    assign pc_src    = ctrl_q.pc_src;
    assign mem_read  = ctrl_q.mem_read;
    assign mem_write = ctrl_q.mem_write;
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit.
// An instruction-level model expands each instruction into the list of
// cycles it must occupy (state plus every control output), together with
// the mem_ready/branch_taken values to drive in each of those cycles.
module tb_mc_control_unit;
    import riscv_cu_pkg::*;

    localparam int LIMIT = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       branch_taken;
    logic       mem_ready;
    logic [3:0] alu_op;
    logic       rs2_imm_s;
    logic [1:0] w_data_s;
    logic       reg_write, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       mem_read, mem_write, illegal, timeout;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    mc_control_unit #(
        .ALUOP_W       (4),
        .USE_MEM_READY (1'b1),
        .WAIT_LIMIT    (LIMIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7       (funct7),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .alu_op       (alu_op),
        .rs2_imm_s    (rs2_imm_s),
        .w_data_s     (w_data_s),
        .reg_write    (reg_write),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .illegal      (illegal),
        .timeout      (timeout),
        .state_o      (state_o)
    );

    typedef struct packed {
        logic [3:0] state;
        logic [3:0] aluOp;
        logic       rs2Imm;
        logic [1:0] wData;
        logic       regWrite;
        logic       irWrite;
        logic       pcWrite;
        logic [1:0] pcSrc;
        logic       memRead;
        logic       memWrite;
        logic       illegal;
        logic       timeout;
    } obs_t;

    typedef struct {
        obs_t       o;
        logic       memReady;
        logic       taken;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
    } rec_t;

    rec_t       plan[$];
    obs_t       expObs;
    logic       expValid = 1'b0;
    int         tests    = 0;
    int         failures = 0;
    int         cycleNo  = 0;
    logic       stickyIll = 1'b0;
    logic       stickyTo  = 1'b0;
    logic [6:0] curOp;
    logic [2:0] curF3;
    logic [6:0] curF7;

    // Compare every meaningful cycle against the model's expectation.
    always @(negedge clk) begin
        if (expValid) begin
            obs_t got;
            got = '{state_o, alu_op, rs2_imm_s, w_data_s, reg_write, ir_write,
                    pc_write, pc_src, mem_read, mem_write, illegal, timeout};
            tests++;
            if (got !== expObs) begin
                failures++;
                $display("[TB] FAIL cycle%0d: state got %0d want %0d, outputs got %h want %h",
                         cycleNo, got.state, expObs.state, got, expObs);
            end
            cycleNo++;
        end
    end

    function automatic rec_t blank(input logic [3:0] s);
        rec_t r;
        r.o          = '0;
        r.o.state    = s;
        r.o.illegal  = stickyIll;
        r.o.timeout  = stickyTo;
        r.memReady   = 1'($urandom);
        r.taken      = 1'($urandom);
        r.op         = curOp;
        r.f3         = curF3;
        r.f7         = curF7;
        return r;
    endfunction

    // Expand one instruction into its cycles; waits > LIMIT means the
    // memory never answers and the access must time out.
    task automatic planInstr(input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input int waits, input logic taken);
        rec_t r;
        logic [3:0] ms;
        curOp = op; curF3 = f3; curF7 = f7;
        r = blank(S_FETCH); r.o.irWrite = 1'b1; r.o.pcWrite = 1'b1; plan.push_back(r);
        plan.push_back(blank(S_DECODE));
        case (op)
            OP_R: begin
                r = blank(S_EXEC_R); r.o.aluOp = {f7[5], f3}; plan.push_back(r);
                r = blank(S_WB_ALU); r.o.regWrite = 1'b1; plan.push_back(r);
            end
            OP_I: begin
                r = blank(S_EXEC_I); r.o.rs2Imm = 1'b1;
                r.o.aluOp = (f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
                plan.push_back(r);
                r = blank(S_WB_ALU); r.o.regWrite = 1'b1; plan.push_back(r);
            end
            OP_LUI: begin
                r = blank(S_WB_LUI); r.o.regWrite = 1'b1; r.o.wData = 2'b01; plan.push_back(r);
            end
            OP_LOAD, OP_STORE: begin
                r = blank(S_MEM_ADDR); r.o.rs2Imm = 1'b1; plan.push_back(r);
                ms = (op == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                for (int k = 0; k <= LIMIT; k++) begin
                    r = blank(ms);
                    if (op == OP_LOAD) r.o.memRead = 1'b1;
                    else               r.o.memWrite = 1'b1;
                    r.memReady = (k == waits);
                    plan.push_back(r);
                    if (k == waits) break;
                end
                if (waits > LIMIT) begin
                    stickyTo = 1'b1;
                    repeat (4) plan.push_back(blank(S_HALT));
                end else if (op == OP_LOAD) begin
                    r = blank(S_WB_MEM); r.o.regWrite = 1'b1; r.o.wData = 2'b10; plan.push_back(r);
                end
            end
            OP_BRANCH: begin
                r = blank(S_BRANCH); r.o.aluOp = 4'b1000; r.o.pcSrc = 2'b01;
                r.taken = taken; r.o.pcWrite = taken; plan.push_back(r);
            end
            OP_JAL: begin
                r = blank(S_JAL); r.o.regWrite = 1'b1; r.o.wData = 2'b11;
                r.o.pcWrite = 1'b1; r.o.pcSrc = 2'b10; plan.push_back(r);
            end
            default: begin
                stickyIll = 1'b1;
                repeat (4) plan.push_back(blank(S_HALT));
            end
        endcase
    endtask

    // Drive the planned cycles; called at posedge+1 of the first cycle.
    task automatic applyStimulus(input int stopAfter);
        rec_t r;
        int n = 0;
        while (plan.size() > 0 && n < stopAfter) begin
            r = plan.pop_front();
            opcode = r.op; funct3 = r.f3; funct7 = r.f7;
            mem_ready = r.memReady; branch_taken = r.taken;
            expObs = r.o; expValid = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        expValid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            failures++;
            $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Hold reset for a while (checking the cleared outputs), then release
    // mid-cycle so the next cycle is IDLE and the one after is FETCH.
    task automatic applyReset();
        expValid = 1'b0;
        rst_n = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        stickyIll = 1'b0; stickyTo = 1'b0;
        plan.delete();
        repeat (2) @(posedge clk);
        #1;
        expObs = '0; expValid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        expValid = 1'b0;
    endtask

    task automatic randomInstr();
        logic [6:0] ops[7];
        logic [6:0] f7;
        int waits;
        ops = '{OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
        case ($urandom_range(0, 2))
            0:       f7 = 7'b0000000;
            1:       f7 = 7'b0100000;
            default: f7 = 7'($urandom);
        endcase
        waits = ($urandom_range(0, 9) == 0) ? LIMIT : $urandom_range(0, 4);
        planInstr(ops[$urandom_range(0, 6)], 3'($urandom), f7, waits, 1'($urandom));
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
        branch_taken = 1'b0; mem_ready = 1'b0;

        // Pin the model against hand-computed cycle counts and ALU codes.
        planInstr(OP_R, 3'b000, 7'b0000000, 0, 1'b0);
        checkOutput("model_add_cycles", plan.size(), 4);
        cnt = 0;
        foreach (plan[i]) if (plan[i].o.regWrite) cnt++;
        checkOutput("model_add_regwrite", cnt, 1);
        plan.delete();
        planInstr(OP_I, 3'b101, 7'b0100000, 0, 1'b0);
        checkOutput("model_srai_aluop", int'(plan[2].o.aluOp), 13);
        plan.delete();
        planInstr(OP_I, 3'b000, 7'b1111111, 0, 1'b0);
        checkOutput("model_addi_aluop", int'(plan[2].o.aluOp), 0);
        plan.delete();
        planInstr(OP_LUI, 3'b000, 7'b0, 0, 1'b0);
        checkOutput("model_lui_cycles", plan.size(), 3);
        plan.delete();
        planInstr(OP_LOAD, 3'b010, 7'b0, 0, 1'b0);
        checkOutput("model_load_cycles", plan.size(), 5);
        plan.delete();
        planInstr(OP_STORE, 3'b010, 7'b0, 0, 1'b0);
        checkOutput("model_store_cycles", plan.size(), 4);
        plan.delete();
        planInstr(OP_LOAD, 3'b010, 7'b0, 3, 1'b0);
        cnt = 0;
        foreach (plan[i]) if (plan[i].o.memRead) cnt++;
        checkOutput("model_lw_wait3_memread", cnt, 4);
        plan.delete();
        planInstr(OP_BRANCH, 3'b000, 7'b0, 0, 1'b1);
        checkOutput("model_branch_cycles", plan.size(), 3);
        plan.delete();
        planInstr(OP_JAL, 3'b000, 7'b0, 0, 1'b0);
        checkOutput("model_jal_cycles", plan.size(), 3);
        plan.delete();

        applyReset();

        // Directed program.
        planInstr(OP_R, 3'b000, 7'b0000000, 0, 1'b0);
        planInstr(OP_I, 3'b101, 7'b0100000, 0, 1'b0);
        planInstr(OP_I, 3'b000, 7'b1111111, 0, 1'b0);
        planInstr(OP_LOAD, 3'b010, 7'b0, 3, 1'b0);
        planInstr(OP_BRANCH, 3'b000, 7'b0, 0, 1'b1);
        planInstr(OP_BRANCH, 3'b000, 7'b0, 0, 1'b0);
        planInstr(OP_JAL, 3'b000, 7'b0, 0, 1'b0);
        planInstr(OP_LUI, 3'b000, 7'b0, 0, 1'b0);
        planInstr(OP_LOAD, 3'b010, 7'b0, LIMIT, 1'b0);
        planInstr(OP_STORE, 3'b010, 7'b0, 0, 1'b0);
        planInstr(OP_R, 3'b000, 7'b0100000, 0, 1'b0);
        applyStimulus(10000);

        // Store that never completes: timeout halt, held until reset.
        planInstr(OP_STORE, 3'b010, 7'b0, 1000, 1'b0);
        applyStimulus(10000);
        applyReset();

        // Random instruction stream.
        for (int i = 0; i < 60; i++) randomInstr();
        applyStimulus(10000);

        // Unknown opcode: sticky illegal halt.
        planInstr(7'b1111111, 3'b000, 7'b0, 0, 1'b0);
        applyStimulus(10000);
        applyReset();

        // Reset asserted while a load is waiting on memory.
        planInstr(OP_LOAD, 3'b010, 7'b0, 10, 1'b0);
        applyStimulus(5);
        #2;
        checkOutput("memrd_before_reset", int'(mem_read), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("memrd_async_reset", int'(mem_read), 0);
        checkOutput("state_async_reset", int'(state_o), 0);
        applyReset();

        // Recovery after reset.
        for (int i = 0; i < 15; i++) randomInstr();
        applyStimulus(10000);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
